mac_rx_filter: RTL and testbench

MAC_RX_FILTER -- requirements
Module: mac_rx_filter

---
 rtl/mac_rx_filter.sv | 198 +++++++++++++++++++
 tb/tb_mac_rx_filter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_filter.sv
// GMII receive parser: preamble/SFD check, dest-MAC filter, FCS strip, per-frame status and counters.
// Latency: payload byte out 5 cycles after sampling; frame status 1 cycle after the last payload byte.
// Backpressure: none, output is a pure stream; CRC check only when MAC_RX_FILTER_CRC_CHECK_EN is defined.
module mac_rx_filter #(
    parameter logic [47:0] P_LOCAL_MAC    = 48'h00_00_00_00_00_00,
    parameter int          P_MIN_FRAME    = 64,
    parameter int          P_MAX_FRAME    = 1518,
    parameter bit          P_BCAST_ACCEPT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_local_mac,
    input  logic        i_local_mac_valid,
    input  logic [7:0]  i_gmii_data,
    input  logic        i_gmii_valid,
    output logic [7:0]  o_post_data,
    output logic        o_post_valid,
    output logic        o_post_last,
    output logic [15:0] o_post_type,
    output logic [47:0] o_recv_src_mac,
    output logic        o_recv_src_mac_valid,
    output logic        o_frame_done,
    output logic        o_frame_good,
    output logic [2:0]  o_frame_err,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_err_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DROP} state_t;

    localparam logic [15:0] LEN_SAT = 16'(P_MAX_FRAME + 1);
    localparam logic [15:0] LEN_MAX = 16'(P_MAX_FRAME);
    localparam logic [15:0] LEN_MIN = 16'(P_MIN_FRAME);

    state_t          state;
    logic [2:0]      pre_cnt;
    logic [15:0]     len;
    logic [47:0]     mac_reg;
    logic [47:0]     frame_mac;
    logic [55:0]     hdr_sh;
    logic [4:0][7:0] dl;
    logic [4:0]      dv;
    logic            prev_vld;
    logic            pend;
    logic [2:0]      pend_err;

    logic [63:0] hdr_now;
    logic [47:0] dest_now;
    logic        dest_ok;
    logic        pay_in;
    logic [15:0] len_inc;
    logic        crc_bad;
    logic [2:0]  end_err;

    assign hdr_now  = {hdr_sh, i_gmii_data};
    assign dest_now = hdr_now[47:0];
    assign dest_ok  = (dest_now == frame_mac) ||
                      (P_BCAST_ACCEPT && (dest_now == 48'hFFFF_FFFF_FFFF));
    assign pay_in   = (state == S_PAYLOAD) && i_gmii_valid;
    assign len_inc  = (len < LEN_SAT) ? len + 16'd1 : len;
    assign end_err  = {len > LEN_MAX, len < LEN_MIN, crc_bad};

`ifdef MAC_RX_FILTER_CRC_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            crc <= 32'hFFFF_FFFF;
        else if (state == S_PREAMBLE)
            crc <= 32'hFFFF_FFFF;
        else if (i_gmii_valid && (state == S_HEADER || state == S_PAYLOAD))
            crc <= crc_byte(crc, i_gmii_data);
    end

    // Running CRC over dest..FCS lands on the fixed residue for an intact frame.
    assign crc_bad = (crc != 32'hDEBB_20E3);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                <= S_IDLE;
            pre_cnt              <= '0;
            len                  <= '0;
            mac_reg              <= P_LOCAL_MAC;
            frame_mac            <= '0;
            hdr_sh               <= '0;
            dl                   <= '0;
            dv                   <= '0;
            prev_vld             <= 1'b1;
            pend                 <= 1'b0;
            pend_err             <= '0;
            o_post_data          <= '0;
            o_post_valid         <= 1'b0;
            o_post_last          <= 1'b0;
            o_post_type          <= '0;
            o_recv_src_mac       <= '0;
            o_recv_src_mac_valid <= 1'b0;
            o_frame_done         <= 1'b0;
            o_frame_good         <= 1'b0;
            o_frame_err          <= '0;
            o_good_cnt           <= '0;
            o_err_cnt            <= '0;
        end else begin
            prev_vld <= i_gmii_valid;
            if (i_local_mac_valid)
                mac_reg <= i_local_mac;

            // A byte leaves the delay line only once four later bytes prove it is not FCS.
            dl           <= {dl[3:0], i_gmii_data};
            dv           <= {dv[3:0], pay_in};
            o_post_data  <= dl[4];
            o_post_valid <= dv[4] & dv[0];
            o_post_last  <= dv[4] & dv[0] & ~pay_in;

            o_recv_src_mac_valid <= 1'b0;
            pend                 <= 1'b0;
            o_frame_done         <= pend;
            o_frame_good         <= pend && (pend_err == 3'b000);
            o_frame_err          <= pend ? pend_err : 3'b000;
            if (pend) begin
                if (pend_err == 3'b000) begin
                    if (o_good_cnt != 16'hFFFF)
                        o_good_cnt <= o_good_cnt + 16'd1;
                end else if (o_err_cnt != 16'hFFFF) begin
                    o_err_cnt <= o_err_cnt + 16'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_gmii_valid) begin
                        // Still-valid line after reset means we joined mid-frame.
                        if (i_gmii_data == 8'h55 && !prev_vld) begin
                            state   <= S_PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!i_gmii_valid) begin
                        state <= S_DROP;
                    end else if (i_gmii_data == 8'hD5) begin
                        state     <= S_HEADER;
                        len       <= '0;
                        frame_mac <= i_local_mac_valid ? i_local_mac : mac_reg;
                    end else if (i_gmii_data == 8'h55 && pre_cnt != 3'd7) begin
                        pre_cnt <= pre_cnt + 3'd1;
                    end else begin
                        state <= S_DROP;
                    end
                end
                S_HEADER: begin
                    if (!i_gmii_valid) begin
                        pend     <= 1'b1;
                        pend_err <= 3'b010;
                        state    <= S_IDLE;
                    end else begin
                        len    <= len_inc;
                        hdr_sh <= hdr_now[55:0];
                        if (len == 16'd5 && !dest_ok)
                            state <= S_DROP;
                        if (len == 16'd13) begin
                            o_recv_src_mac       <= hdr_now[63:16];
                            o_post_type          <= hdr_now[15:0];
                            o_recv_src_mac_valid <= 1'b1;
                            state                <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (!i_gmii_valid) begin
                        pend     <= 1'b1;
                        pend_err <= end_err;
                        state    <= S_IDLE;
                    end else begin
                        len <= len_inc;
                    end
                end
                S_DROP: begin
                    if (!i_gmii_valid)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_rx_filter.sv
// Directed bench for mac_rx_filter: frames built with real FCS, payload checked byte by byte.
module tb_mac_rx_filter;
    localparam logic [47:0] LOCAL  = 48'h02_11_22_33_44_55;
    localparam logic [47:0] NEWMAC = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [47:0] OTHER  = 48'h02_11_22_33_44_56;
    localparam logic [47:0] SRC    = 48'h0A_0B_0C_0D_0E_0F;
`ifdef MAC_RX_FILTER_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] lm  = '0;
    logic        lmv = 1'b0;
    logic [7:0]  gd  = '0;
    logic        gv  = 1'b0;
    logic [7:0]  o_post_data;
    logic        o_post_valid, o_post_last, o_recv_src_mac_valid;
    logic [15:0] o_post_type, o_good_cnt, o_err_cnt;
    logic [47:0] o_recv_src_mac;
    logic        o_frame_done, o_frame_good;
    logic [2:0]  o_frame_err;

    mac_rx_filter #(.P_LOCAL_MAC(LOCAL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_local_mac(lm), .i_local_mac_valid(lmv),
        .i_gmii_data(gd), .i_gmii_valid(gv),
        .o_post_data(o_post_data), .o_post_valid(o_post_valid), .o_post_last(o_post_last),
        .o_post_type(o_post_type),
        .o_recv_src_mac(o_recv_src_mac), .o_recv_src_mac_valid(o_recv_src_mac_valid),
        .o_frame_done(o_frame_done), .o_frame_good(o_frame_good), .o_frame_err(o_frame_err),
        .o_good_cnt(o_good_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int exp_good = 0, exp_err = 0;
    logic [7:0] exp_pay [0:2047];
    logic [7:0] frm [$];

    int pcount = 0, last_cnt = 0, done_cnt = 0, src_cnt = 0, gap_cnt = 0, data_err = 0;
    int fidx = 0, last_pos = 0, first_out_cyc = 0, last_cyc = 0, done_cyc = 0;
    bit in_frame = 1'b0;
    logic done_good = 1'b0;
    logic [2:0] done_err = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (o_post_valid) begin
                if (!in_frame) begin
                    fidx = 0;
                    first_out_cyc = cyc;
                    in_frame = 1'b1;
                end
                if (fidx > 2047 || o_post_data !== exp_pay[fidx]) data_err++;
                fidx++;
                pcount++;
                if (o_post_last) begin
                    last_cnt++;
                    last_pos = fidx;
                    last_cyc = cyc;
                    in_frame = 1'b0;
                end
            end else if (in_frame) begin
                gap_cnt++;
            end
            if (o_recv_src_mac_valid) src_cnt++;
            if (o_frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_good = o_frame_good;
                done_err = o_frame_err;
            end
        end
    end

    int b_pc, b_last, b_done, b_src, pay_drive_cyc, rst_pc;
    logic rst_snap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_pc = pcount; b_last = last_cnt; b_done = done_cnt; b_src = src_cnt;
    endtask

    task automatic build(input logic [47:0] dest, input logic [15:0] typ, input int plen,
                         input bit flip, input logic [7:0] seed);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(SRC[47-8*i -: 8]);
        frm.push_back(typ[15:8]);
        frm.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) begin
            exp_pay[i] = 8'(i * 13) + seed;
            frm.push_back(exp_pay[i]);
        end
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        if (flip) c[3] = ~c[3];
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic drive(input logic [7:0] d);
        @(negedge clk);
        gv = 1'b1;
        gd = d;
    endtask

    task automatic send(input int npre, input int nsend, input int rst_at, input int gap);
        for (int i = 0; i < npre; i++) drive(8'h55);
        drive(8'hD5);
        for (int i = 0; i < nsend; i++) begin
            drive(frm[i]);
            if (i == 14) pay_drive_cyc = cyc;
            if (i == rst_at) begin
                #1 rst = 1'b1;
                @(negedge clk);
                rst_snap = |{o_post_data, o_post_valid, o_post_last, o_post_type, o_recv_src_mac,
                             o_recv_src_mac_valid, o_frame_done, o_frame_good, o_frame_err,
                             o_good_cnt, o_err_cnt};
                rst_pc = pcount;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        gv = 1'b0;
        gd = 8'h00;
        for (int i = 1; i < gap; i++) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input int npay, input int nlast,
                                input int ndone, input logic [2:0] err);
        check({tag, ".pay"},  64'(pcount - b_pc),     64'(npay));
        check({tag, ".last"}, 64'(last_cnt - b_last), 64'(nlast));
        check({tag, ".done"}, 64'(done_cnt - b_done), 64'(ndone));
        if (ndone > 0) begin
            check({tag, ".err"},  64'(done_err),  64'(err));
            check({tag, ".good"}, 64'(done_good), 64'(err == 3'b000));
        end
        check({tag, ".gcnt"}, 64'(o_good_cnt), 64'(exp_good));
        check({tag, ".ecnt"}, 64'(o_err_cnt),  64'(exp_err));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.valid", 64'(o_post_valid), 64'(0));
        check("rst.done",  64'(o_frame_done), 64'(0));
        check("rst.gcnt",  64'(o_good_cnt),   64'(0));
        check("rst.ecnt",  64'(o_err_cnt),    64'(0));
        check("rst.type",  64'(o_post_type),  64'(0));
        check("rst.src",   64'(o_recv_src_mac), 64'(0));
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        build(LOCAL, 16'h0800, 46, 1'b0, 8'h11); mark(); send(7, frm.size(), -1, 8);
        exp_good++;
        expect_frame("basic", 46, 1, 1, 3'b000);
        check("basic.lastpos", 64'(last_pos), 64'(46));
        check("basic.type",    64'(o_post_type), 64'(16'h0800));
        check("basic.src",     64'(o_recv_src_mac), 64'(SRC));
        check("basic.srcvld",  64'(src_cnt - b_src), 64'(1));
        check("basic.lat",     64'(first_out_cyc - pay_drive_cyc), 64'(6));
        check("basic.donelat", 64'(done_cyc - last_cyc), 64'(1));

        build(LOCAL, 16'h0800, 46, 1'b1, 8'h22); mark(); send(7, frm.size(), -1, 8);
        if (CRC_ON) exp_err++; else exp_good++;
        expect_frame("badfcs", 46, 1, 1, CRC_ON ? 3'b001 : 3'b000);

        build(48'hFFFF_FFFF_FFFF, 16'h0806, 46, 1'b0, 8'h33); mark(); send(7, frm.size(), -1, 8);
        exp_good++;
        expect_frame("bcast", 46, 1, 1, 3'b000);
        check("bcast.type", 64'(o_post_type), 64'(16'h0806));

        build(OTHER, 16'h86DD, 46, 1'b0, 8'h44); mark(); send(7, frm.size(), -1, 8);
        expect_frame("other", 0, 0, 0, 3'b000);
        check("other.type",   64'(o_post_type), 64'(16'h0806));
        check("other.srcvld", 64'(src_cnt - b_src), 64'(0));

        build(LOCAL, 16'h0800, 50, 1'b0, 8'h55); mark(); send(6, frm.size(), -1, 8);
        exp_good++;
        expect_frame("pre6", 50, 1, 1, 3'b000);

        build(LOCAL, 16'h0800, 46, 1'b0, 8'h66); mark();
        drive(8'h55); drive(8'h12);
        send(7, frm.size(), -1, 1);
        send(7, frm.size(), -1, 8);
        exp_good++;
        expect_frame("badpre", 46, 1, 1, 3'b000);

        build(LOCAL, 16'h0800, 42, 1'b0, 8'h77); mark(); send(7, frm.size(), -1, 8);
        exp_err++;
        expect_frame("runt60", 42, 1, 1, 3'b010);

        build(LOCAL, 16'h0800, 1501, 1'b0, 8'h88); mark(); send(7, frm.size(), -1, 8);
        exp_err++;
        expect_frame("giant", 1501, 1, 1, 3'b100);
        check("giant.lastpos", 64'(last_pos), 64'(1501));

        build(LOCAL, 16'h0800, 46, 1'b0, 8'h99); mark(); send(7, 10, -1, 8);
        exp_err++;
        expect_frame("hdrdrop", 0, 0, 1, 3'b010);
        check("hdrdrop.srcvld", 64'(src_cnt - b_src), 64'(0));

        build(LOCAL, 16'h0800, 0, 1'b0, 8'hAA); mark(); send(7, frm.size(), -1, 8);
        exp_err++;
        expect_frame("nopay", 0, 0, 1, 3'b010);

        @(negedge clk); lm = NEWMAC; lmv = 1'b1;
        @(negedge clk); lmv = 1'b0;
        build(LOCAL, 16'h0800, 46, 1'b0, 8'hBB); mark(); send(7, frm.size(), -1, 8);
        expect_frame("oldmac", 0, 0, 0, 3'b000);
        build(NEWMAC, 16'h0800, 46, 1'b0, 8'hCC); mark(); send(7, frm.size(), -1, 8);
        exp_good++;
        expect_frame("newmac", 46, 1, 1, 3'b000);

        build(NEWMAC, 16'h0800, 46, 1'b0, 8'hDD); mark();
        send(7, frm.size(), -1, 1);
        send(7, frm.size(), -1, 8);
        exp_good += 2;
        expect_frame("b2b", 92, 2, 2, 3'b000);

        build(NEWMAC, 16'h0800, 46, 1'b0, 8'hEE); mark(); send(7, frm.size(), 34, 8);
        check("midrst.outs", 64'(rst_snap), 64'(0));
        check("midrst.pay",  64'(pcount), 64'(rst_pc));
        check("midrst.done", 64'(done_cnt - b_done), 64'(0));
        exp_good = 0;
        exp_err = 0;
        build(LOCAL, 16'h0800, 46, 1'b0, 8'h5A); mark(); send(7, frm.size(), -1, 8);
        exp_good++;
        expect_frame("afterrst", 46, 1, 1, 3'b000);

        check("all.data", 64'(data_err), 64'(0));
        check("all.gap",  64'(gap_cnt),  64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
